stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 105 ++++++++++
 tb/tb_stream_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Packs Ratio narrow words into one wide beat with a per-lane keep mask.
// Partial beats leave on an explicit flush or after an idle timeout.
module stream_packer #(
  parameter int DataWidth   = 4,
  parameter int Ratio       = 4,
  parameter int IdleTimeout = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth*Ratio-1:0] data_o,
  output logic [Ratio-1:0]           keep_o
);

  localparam int CntW  = $clog2(Ratio + 1);
  localparam int IdleW = $clog2(IdleTimeout + 1);
  localparam int BeatW = DataWidth * Ratio;

  logic [BeatW-1:0] acc_data_p0;
  logic [CntW-1:0]  count_p0;
  logic [IdleW-1:0] idle_p0;
  logic             flush_pend_p0;

  logic             accept;
  logic             out_free;
  logic             full_now;
  logic             flush_want;
  logic             emit;
  logic [CntW-1:0]  cnt_after;
  logic [BeatW-1:0] beat;
  logic [Ratio-1:0] beat_keep;

  // Only the last free lane can be blocked: earlier lanes always have room.
  assign ready_o  = !((count_p0 == CntW'(Ratio - 1)) && valid_o && !ready_i);
  assign accept   = valid_i && ready_o;
  assign out_free = !valid_o || ready_i;
  assign cnt_after = count_p0 + CntW'(accept);
  assign full_now  = (cnt_after == CntW'(Ratio));

  assign flush_want = flush_pend_p0
                   || ((count_p0 != '0) && (idle_p0 == IdleW'(IdleTimeout)))
                   || (flush_i && (cnt_after != '0));

  // A full beat always finds the output register free thanks to ready_o.
  assign emit = full_now || (flush_want && out_free && (cnt_after != '0));

  always_comb begin
    beat      = acc_data_p0;
    beat_keep = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (accept && (CntW'(k) == count_p0)) begin
        beat[k*DataWidth +: DataWidth] = data_i;
      end
      if (CntW'(k) < cnt_after) begin
        beat_keep[k] = 1'b1;
      end
    end
  end

  // Stage p0: accumulator, fill count, idle counter, pending flush
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_data_p0   <= '0;
      count_p0      <= '0;
      idle_p0       <= '0;
      flush_pend_p0 <= 1'b0;
    end else begin
      if (emit) begin
        acc_data_p0   <= '0;
        count_p0      <= '0;
        flush_pend_p0 <= 1'b0;
      end else begin
        acc_data_p0   <= beat;
        count_p0      <= cnt_after;
        flush_pend_p0 <= flush_want && (cnt_after != '0);
      end
      if (emit || accept || (count_p0 == '0)) begin
        idle_p0 <= '0;
      end else if (idle_p0 != IdleW'(IdleTimeout)) begin
        idle_p0 <= idle_p0 + IdleW'(1);
      end
    end
  end

  // Stage p1: output register, held stable under backpressure
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
    end else if (emit) begin
      valid_o <= 1'b1;
      data_o  <= beat;
      keep_o  <= beat_keep;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer with a scoreboard of expected beats.
module tb_stream_packer;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  data_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;
  logic [3:0]  keep_o;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  k;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    xfers  = 0;

  stream_packer #(.DataWidth(4), .Ratio(4), .IdleTimeout(16)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .keep_o  (keep_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs only change at posedge+1, so negedge state is what the next edge sees.
  always @(negedge clk_i) begin
    if (reset_ni && valid_o && ready_i) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {12'h0, keep_o, data_o}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", {16'h0, data_o}, {16'h0, e.d});
        chk("beat_keep", {28'h0, keep_o}, {28'h0, e.k});
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] k);
    beat_t e;
    e.d = d;
    e.k = k;
    exp_q.push_back(e);
  endtask

  // Presents one word and returns after the edge that accepted it.
  task automatic word(input logic [3:0] d, input logic fl, output int edges);
    logic took;
    valid_i = 1'b1;
    data_i  = d;
    flush_i = fl;
    edges   = 0;
    took    = 1'b0;
    while (!took && edges < 50) begin
      #1;
      took = ready_o;
      @(posedge clk_i);
      #1;
      edges++;
    end
    if (!took) chk("accept_timeout", 32'(edges), 32'd0);
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic words(input logic [3:0] first, input int n);
    int e;
    for (int i = 0; i < n; i++) word(first + 4'(i), 1'b0, e);
  endtask

  initial begin
    int e;
    int n;
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    data_i   = '0;
    ready_i  = 1'b1;
    #12;
    chk("rst_valid", {31'h0, valid_o}, 32'd0);
    chk("rst_data",  {16'h0, data_o}, 32'd0);
    chk("rst_keep",  {28'h0, keep_o}, 32'd0);
    chk("rst_ready", {31'h0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;

    // Full pack
    push(16'h4321, 4'hF);
    word(4'h1, 1'b0, e);
    chk("first_accept_edges", 32'(e), 32'd1);
    words(4'h2, 3);
    chk("full_valid", {31'h0, valid_o}, 32'd1);
    chk("full_data",  {16'h0, data_o}, 32'h4321);
    chk("full_keep",  {28'h0, keep_o}, 32'hF);
    step(2);

    // Idle timeout flush
    push(16'h0765, 4'h7);
    words(4'h5, 3);
    n = 0;
    while (!valid_o && n < 40) begin
      step(1);
      n++;
    end
    chk("timeout_fired", {31'h0, valid_o}, 32'd1);
    chk("timeout_not_early", {31'h0, (n >= 16 && n <= 17)}, 32'd1);
    chk("timeout_data", {16'h0, data_o}, 32'h0765);
    chk("timeout_keep", {28'h0, keep_o}, 32'h7);
    step(2);

    // Backpressure
    ready_i = 1'b0;
    push(16'h4321, 4'hF);
    push(16'h8765, 4'hF);
    words(4'h1, 7);
    valid_i = 1'b1;
    data_i  = 4'h8;
    #1;
    chk("bp_ready_low", {31'h0, ready_o}, 32'd0);
    chk("bp_held_data", {16'h0, data_o}, 32'h4321);
    step(3);
    chk("bp_still_low", {31'h0, ready_o}, 32'd0);
    chk("bp_stable_data", {16'h0, data_o}, 32'h4321);
    chk("bp_stable_valid", {31'h0, valid_o}, 32'd1);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_comb", {31'h0, ready_o}, 32'd1);
    step(1);
    valid_i = 1'b0;
    chk("bp_next_data", {16'h0, data_o}, 32'h8765);
    chk("bp_next_keep", {28'h0, keep_o}, 32'hF);
    step(2);

    // Explicit flush, then a flush with nothing buffered
    push(16'h00A9, 4'h3);
    word(4'h9, 1'b0, e);
    word(4'hA, 1'b1, e);
    chk("flush_valid", {31'h0, valid_o}, 32'd1);
    chk("flush_data", {16'h0, data_o}, 32'h00A9);
    chk("flush_keep", {28'h0, keep_o}, 32'h3);
    step(2);
    n = xfers;
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    chk("empty_flush_valid", {31'h0, valid_o}, 32'd0);
    step(3);
    chk("empty_flush_xfers", 32'(xfers), 32'(n));

    // Reset with a held beat and a partial beat in flight
    ready_i = 1'b0;
    words(4'h1, 6);
    chk("pre_rst_valid", {31'h0, valid_o}, 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, valid_o}, 32'd0);
    chk("mid_rst_keep",  {28'h0, keep_o}, 32'd0);
    chk("mid_rst_ready", {31'h0, ready_o}, 32'd1);
    step(1);
    reset_ni = 1'b1;
    ready_i  = 1'b1;
    push(16'h4321, 4'hF);
    words(4'h1, 4);
    chk("post_rst_data", {16'h0, data_o}, 32'h4321);
    chk("post_rst_keep", {28'h0, keep_o}, 32'hF);
    step(2);

    // Flush held off by backpressure
    ready_i = 1'b0;
    push(16'h4321, 4'hF);
    push(16'h00CB, 4'h3);
    words(4'h1, 4);
    word(4'hB, 1'b0, e);
    word(4'hC, 1'b1, e);
    step(3);
    chk("bpf_held_data", {16'h0, data_o}, 32'h4321);
    chk("bpf_held_keep", {28'h0, keep_o}, 32'hF);
    ready_i = 1'b1;
    step(1);
    chk("bpf_partial_valid", {31'h0, valid_o}, 32'd1);
    chk("bpf_partial_data", {16'h0, data_o}, 32'h00CB);
    chk("bpf_partial_keep", {28'h0, keep_o}, 32'h3);
    step(3);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
